sram_rw_port_arbiter: RTL
=========================

Name: sram_rw_port_arbiter

Overview:
- Round-robin arbiter sharing port 0 (RW) of the 1rw1r OpenRAM macro, sram_1rw1r_32_256_8_sky130, between two requesters, m0 and m1.
- Sits between the two requesters and the macro's clk0/csb0/web0/wmask0/addr0/din0/dout0 pins.
- Issues at most one access per cycle through registered macro-side outputs.
- Returns read data on a single response bus tagged with the requester id.
- Port 1 of the macro is out of scope for this block.

Parameters:
DATA_WIDTH, 32, data word width; must equal 8*NUM_WMASKS
ADDR_WIDTH, 8, word address width
NUM_WMASKS, 4, byte write-enable count
RSP_DEPTH, 4, response FIFO depth; used only with SRAM_ARB_RSP_BUF_EN; must be >=3

Ports:
clk  in  1  clock; also drives macro clk0
rst  in  1  reset, synchronous, active-high
mN_req_valid  in  1  request valid (N=0,1)
mN_req_ready  out  1  request accepted this cycle (N=0,1)
mN_req_we  in  1  1=write, 0=read
mN_req_wmask  in  NUM_WMASKS  byte enables; writes only
mN_req_addr  in  ADDR_WIDTH  word address
mN_req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  read data valid
rsp_id  out  1  requester that issued the read: 0=m0, 1=m1
rsp_data  out  DATA_WIDTH  read data
rsp_ready  in  1  response consumer ready; ignored without SRAM_ARB_RSP_BUF_EN
sram_csb0  out  1  macro chip select, active low
sram_web0  out  1  macro write enable, active low
sram_wmask0  out  NUM_WMASKS  macro write mask
sram_addr0  out  ADDR_WIDTH  macro address
sram_din0  out  DATA_WIDTH  macro write data
sram_dout0  in  DATA_WIDTH  macro read data

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Values during reset and in the cycle after: sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, rsp_valid=0, rsp_id=0, rsp_data=0, mN_req_ready=0.
- Handshake: a request transfers in cycle T when mN_req_valid=1 and mN_req_ready=1.
  - mN_req_ready is combinational from the valids, the RR pointer and credit availability.
  - At most one ready is high per cycle.
  - A requester holds valid and its payload stable until the request is accepted.
- Round-robin arbitration:
  - 1-bit pointer; reset value favours m0.
  - If both requesters are valid, grant the one not granted last.
  - If only one is valid, grant it. The pointer updates only on a grant.
- Issue pipeline:
  - Accepted in cycle T: the payload is registered onto sram_* at the end of T and driven during T+1, with csb0=0 and web0=~we. The macro samples it at the end of T+1.
  - Any cycle with no grant: sram_csb0=1 in the next cycle; other sram_* outputs hold their values.
  - Back-to-back grants are allowed every cycle, for reads and writes mixed.
- Read return:
  - The macro's dout0 is valid only between the negedge of T+2 and the posedge ending T+2. The block registers sram_dout0 at that posedge.
  - Without the buffer, rsp_valid=1 for exactly one cycle, T+3, with rsp_id = the granted requester. Fixed read latency is 3 cycles.
  - A 2-stage in-flight tag pipeline of {valid, id} is aligned to this timing.
- Writes: no response. Accesses complete in grant order, so a read granted after a write to the same address returns the new data.
- rsp_data holds its last value when rsp_valid=0.
- Reset mid-operation:
  - In-flight tags are cleared; responses to reads accepted before reset are dropped.
  - The pointer returns to m0.
  - sram_csb0 is forced to 1 so no spurious write reaches the macro.

Optional Feature:
SRAM_ARB_RSP_BUF_EN
- Defined:
  - rsp_* comes from a RSP_DEPTH-entry FIFO of {id, data} with valid/ready on rsp_valid/rsp_ready.
  - Credit counter = FIFO occupancy + reads in flight. A read is granted only if credit < RSP_DEPTH; writes are never blocked.
  - If the RR winner is a blocked read, the other requester may be granted this cycle.
  - FIFO full and pop in the same cycle as a push: both occur.
  - Reset flushes the FIFO and zeroes credits.
  - rsp_valid is first visible in cycle T+3.
- Undefined: rsp_ready is ignored, responses are fire-and-forget, and credit logic is absent.

Test Plan:
- Reset: assert rst 2 cycles with both valids high -> both readys=0, sram_csb0=1, rsp_valid=0 throughout, and for 1 cycle after release.
- Write then read: m0 write addr=0x10, wdata=0xDEADBEEF, wmask=0xF, then m0 read addr=0x10 next cycle -> rsp_valid at read T+3, rsp_id=0, rsp_data=0xDEADBEEF.
- Byte mask: write 0x11223344 mask=0xF, then 0xAABBCCDD mask=0x5 to addr 0x20, then read -> 0x11BB33DD.
- Fairness: m0 and m1 continuously valid with reads to 0x01 and 0x02 -> grants alternate m0,m1,m0,...; rsp_id alternates 0,1,0,... at 1 response per cycle.
- Reset mid-read: m1 read accepted, rst asserted at T+1 -> no rsp_valid in T+3, pointer back to m0.
- With SRAM_ARB_RSP_BUF_EN and RSP_DEPTH=4: hold rsp_ready=0 with m0 reads continuous -> exactly 4 reads accepted, then m0_req_ready=0 while m1 writes still granted. Release rsp_ready -> 4 responses in order, then reads resume.

Source files
------------

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the RW port of sram_1rw1r_32_256_8_sky130 between m0 and m1.
// Optional response FIFO with read credits is enabled by defining SRAM_ARB_RSP_BUF_EN.
module sram_rw_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WMASKS = 4,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic                  m0_req_we,
   input  logic [NUM_WMASKS-1:0] m0_req_wmask,
   input  logic [ADDR_WIDTH-1:0] m0_req_addr,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata,
   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic                  m1_req_we,
   input  logic [NUM_WMASKS-1:0] m1_req_wmask,
   input  logic [ADDR_WIDTH-1:0] m1_req_addr,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  rsp_ready,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   logic                  rst_q_r;
   logic                  ptr_r;
   logic                  tag1_v_r, tag1_id_r, tag2_v_r, tag2_id_r;
   logic                  credit_ok_s;
   logic                  elig0_s, elig1_s, gnt0_s, gnt1_s, gnt_any_s;
   logic                  gnt_we_s;
   logic [NUM_WMASKS-1:0] gnt_wmask_s;
   logic [ADDR_WIDTH-1:0] gnt_addr_s;
   logic [DATA_WIDTH-1:0] gnt_wdata_s;

   // Grant selection: ptr_r=0 favours m0; nothing is granted in reset or the cycle after it
   always_comb begin
      elig0_s   = m0_req_valid & (m0_req_we | credit_ok_s) & ~rst & ~rst_q_r;
      elig1_s   = m1_req_valid & (m1_req_we | credit_ok_s) & ~rst & ~rst_q_r;
      gnt0_s    = elig0_s & (~elig1_s | ~ptr_r);
      gnt1_s    = elig1_s & (~elig0_s | ptr_r);
      gnt_any_s = gnt0_s | gnt1_s;
   end

   assign m0_req_ready = gnt0_s;
   assign m1_req_ready = gnt1_s;

   // Payload of the granted requester
   always_comb begin
      gnt_we_s    = m0_req_we;
      gnt_wmask_s = m0_req_wmask;
      gnt_addr_s  = m0_req_addr;
      gnt_wdata_s = m0_req_wdata;
      if (gnt1_s) begin
         gnt_we_s    = m1_req_we;
         gnt_wmask_s = m1_req_wmask;
         gnt_addr_s  = m1_req_addr;
         gnt_wdata_s = m1_req_wdata;
      end else begin
         gnt_we_s    = m0_req_we;
         gnt_wmask_s = m0_req_wmask;
         gnt_addr_s  = m0_req_addr;
         gnt_wdata_s = m0_req_wdata;
      end
   end

   // Macro-side issue registers; idle cycles only deselect the macro
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= {NUM_WMASKS{1'b0}};
         sram_addr0  <= {ADDR_WIDTH{1'b0}};
         sram_din0   <= {DATA_WIDTH{1'b0}};
      end else if (gnt_any_s) begin
         sram_csb0   <= 1'b0;
         sram_web0   <= ~gnt_we_s;
         sram_wmask0 <= gnt_wmask_s;
         sram_addr0  <= gnt_addr_s;
         sram_din0   <= gnt_wdata_s;
      end else begin
         sram_csb0   <= 1'b1;
      end
   end

   // Pointer and in-flight read tags aligned to the macro's read latency
   always_ff @(posedge clk) begin
      rst_q_r <= rst;
      if (rst) begin
         ptr_r     <= 1'b0;
         tag1_v_r  <= 1'b0;
         tag1_id_r <= 1'b0;
         tag2_v_r  <= 1'b0;
         tag2_id_r <= 1'b0;
      end else begin
         if (gnt_any_s) begin
            ptr_r <= gnt0_s;
         end
         tag1_v_r  <= gnt_any_s & ~gnt_we_s;
         tag1_id_r <= gnt1_s;
         tag2_v_r  <= tag1_v_r;
         tag2_id_r <= tag1_id_r;
      end
   end

`ifdef SRAM_ARB_RSP_BUF_EN
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [DATA_WIDTH:0] fifo_mem_r [RSP_DEPTH];
   logic [PW-1:0]       rd_ptr_r, wr_ptr_r, prev_ptr_s;
   logic [CW-1:0]       count_r;
   logic [CW:0]         credit_s;
   logic [DATA_WIDTH:0] head_s;
   logic                pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? PW'(0) : p + PW'(1);
   endfunction

   // Credits count reads already queued plus reads still in the macro pipeline
   always_comb begin
      credit_s    = (CW+1)'(count_r) + (CW+1)'(tag1_v_r) + (CW+1)'(tag2_v_r);
      credit_ok_s = credit_s < (CW+1)'(RSP_DEPTH);
      pop_s       = (count_r != CW'(0)) & rsp_ready;
      prev_ptr_s  = (rd_ptr_r == PW'(0)) ? PW'(RSP_DEPTH - 1) : rd_ptr_r - PW'(1);
      if (count_r == CW'(0)) begin
         head_s = fifo_mem_r[prev_ptr_s];
      end else begin
         head_s = fifo_mem_r[rd_ptr_r];
      end
   end

   // Response FIFO; credits guarantee a push never meets a full FIFO without a pop
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= PW'(0);
         wr_ptr_r <= PW'(0);
         count_r  <= CW'(0);
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_mem_r[i] <= {(DATA_WIDTH+1){1'b0}};
         end
      end else begin
         if (tag2_v_r) begin
            fifo_mem_r[wr_ptr_r] <= {tag2_id_r, sram_dout0};
            wr_ptr_r             <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         count_r <= count_r + CW'(tag2_v_r) - CW'(pop_s);
      end
   end

   assign rsp_valid = (count_r != CW'(0));
   assign rsp_id    = head_s[DATA_WIDTH];
   assign rsp_data  = head_s[DATA_WIDTH-1:0];
`else
   logic unused_s;

   assign credit_ok_s = 1'b1;
   assign unused_s    = rsp_ready ^ RSP_DEPTH[0];

   // Fire-and-forget response register capturing dout0 at the end of T+2
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= {DATA_WIDTH{1'b0}};
      end else begin
         rsp_valid <= tag2_v_r;
         if (tag2_v_r) begin
            rsp_id   <= tag2_id_r;
            rsp_data <= sram_dout0;
         end
      end
   end
`endif

endmodule
